cok_dongulu_amb: RTL and testbench
==================================

// Module: cok_dongulu_amb
// PURPOSE
//  Parametrised, multi-cycle arithmetic-logic unit for the execute stage.
//  It takes one operation per handshake. Add, sub, logic and compare ops finish in one cycle.
//  Shifts run iteratively, KAYDIRMA_ADIM bits per cycle, to shorten the critical path.
//  The result is registered and held until the consumer accepts it. Flush input serves branch/exception squash.
// PARAMETERS
//  VERI_BIT       32  operand/result width (power of two, >=8)
//  KAYDIRMA_ADIM   8  max bit positions shifted per cycle (power of two, 1..VERI_BIT)
// PORTS
//  clk_i      in   1              clock, all state on rising edge
//  rst_i      in   1              reset, synchronous, active-low
//  temizle_i  in   1              flush: drop in-flight op and result
//  gecerli_i  in   1              input operands/op valid
//  hazir_o    out  1              unit ready to accept an op
//  kontrol_i  in   4              op: 0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//  deger1_i   in   VERI_BIT       operand 1
//  deger2_i   in   VERI_BIT       operand 2 (shift amount = low log2(VERI_BIT) bits)
//  gecerli_o  out  1              result valid
//  hazir_i    in   1              consumer ready for result
//  sonuc_o    out  VERI_BIT       result
// BEHAVIOUR
//  FSM states: BOSTA (idle), KAYDIR (shifting), SONUC (result held).
//  Reset (rst_i=0 at a clock edge):
//   - state=BOSTA; sonuc_o=0; gecerli_o=0; shift counter=0.
//   - hazir_o=1 from the first cycle after reset.
//  hazir_o = (state==BOSTA). An op is accepted on a cycle where gecerli_i & hazir_o.
//  BOSTA, op accepted:
//   - Shift op with amount s>0: latch operand, op and s; go to KAYDIR.
//   - Any other op, or a shift with s==0: compute the result combinationally.
//     Register it into sonuc_o and go to SONUC.
//  KAYDIR, each cycle:
//   - Shift by step=min(KAYDIRMA_ADIM, remaining); remaining -= step.
//   - SRA fills with the original MSB; SLL/SRL fill with 0.
//   - On the cycle remaining reaches 0, write the final value to sonuc_o and go to SONUC.
//  SONUC: gecerli_o=1; sonuc_o held stable. On hazir_i, go to BOSTA the next cycle.
//   There is no same-cycle re-accept (one op in flight; throughput <= 1 op per 2 cycles).
//  Latency, with accept at edge N:
//   - Non-shift op: gecerli_o=1 after edge N+1.
//   - Shift by s>0: gecerli_o=1 after edge N+1+ceil(s/KAYDIRMA_ADIM).
//  Arithmetic:
//   - ADD/SUB use VERI_BIT-bit modulo arithmetic; carry-out is discarded.
//   - SUB = a + ~b + 1.
//  Compare ops (result is 0 or 1, zero-extended):
//   - SLT compares signed operands.
//   - SLTU compares unsigned operands.
//  Undefined kontrol_i (10..15): result 0, single-cycle path. Never X.
//  Flush (temizle_i=1):
//   - Next state is BOSTA; gecerli_o=0 next cycle; sonuc_o keeps its old value.
//   - An op presented with gecerli_i in the same cycle is NOT accepted.
//  Priority: reset > flush > normal operation.
//  gecerli_o never rises without a prior accept. Inputs are ignored outside BOSTA.
// TESTING
//  ADD 0xFFFFFFFF+0x1, hazir_i=1 -> sonuc_o=0x00000000; gecerli_o 1 cycle after accept, for 1 cycle.
//  SUB 5-7 -> 0xFFFFFFFE; SLT(0xFFFFFFFF,1) -> 1; SLTU(0xFFFFFFFF,1) -> 0; op 12 -> 0.
//  SRA 0x80000000 by 31, ADIM=8 -> 4 cycles in KAYDIR; 0xFFFFFFFF valid 5 cycles after accept; hazir_o=0 in between.
//  SLL 0x1 by 0 -> 0x1 after 1 cycle; SRL 0xF0000000 by 8 -> 0x00F00000 after 2 cycles.
//  hazir_i=0 for 3 cycles in SONUC -> sonuc_o/gecerli_o stable; new gecerli_i ignored.
//  temizle_i mid-KAYDIR, and rst_i=0 mid-KAYDIR:
//   -> gecerli_o stays 0; hazir_o=1 next cycle; next ADD 2+3 returns 5.

Source files
------------

// File: rtl/cok_dongulu_amb.sv
// cok_dongulu_amb -- multi-cycle ALU for the execute stage.
//
// Accepts one operation per valid/ready handshake and holds the registered
// result until the consumer takes it. ADD/SUB/logic/compare ops and any
// zero-distance shift finish in one cycle. Non-zero shifts advance by at most
// KAYDIRMA_ADIM bit positions per cycle, which keeps the barrel shifter short.
//
// Ports
//   clk_i      clock, all state on the rising edge
//   rst_i      synchronous active-low reset
//   temizle_i  flush: drops the in-flight op and the pending result
//   gecerli_i  operands/op valid
//   hazir_o    ready to accept an op (high only when idle)
//   kontrol_i  op: 0 ADD,1 SUB,2 XOR,3 OR,4 AND,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU
//   deger1_i   operand 1
//   deger2_i   operand 2 (shift distance = low log2(VERI_BIT) bits)
//   gecerli_o  result valid
//   hazir_i    consumer ready for the result
//   sonuc_o    result, held stable while gecerli_o is high
module cok_dongulu_amb #(
  parameter int VERI_BIT      = 32,
  parameter int KAYDIRMA_ADIM = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                temizle_i,
  input  logic                gecerli_i,
  output logic                hazir_o,
  input  logic [3:0]          kontrol_i,
  input  logic [VERI_BIT-1:0] deger1_i,
  input  logic [VERI_BIT-1:0] deger2_i,
  output logic                gecerli_o,
  input  logic                hazir_i,
  output logic [VERI_BIT-1:0] sonuc_o
);

  localparam int SW = $clog2(VERI_BIT);
  // One extra bit so that a step of KAYDIRMA_ADIM == VERI_BIT is representable.
  localparam int KW = SW + 1;
  localparam logic [KW-1:0] ADIM_K = KW'(KAYDIRMA_ADIM);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SLTU = 4'd9;

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    KAYDIR = 2'd1,
    SONUC  = 2'd2
  } durum_t;

  durum_t              state_reg, state_next;
  logic [VERI_BIT-1:0] sonuc_reg, sonuc_next;
  logic [VERI_BIT-1:0] veri_reg, veri_next;
  logic [3:0]          op_reg, op_next;
  logic [KW-1:0]       kalan_reg, kalan_next;

  logic [SW-1:0]       miktar;
  logic                kaydirma_op;
  logic [VERI_BIT-1:0] tek_sonuc;
  logic [KW-1:0]       adim;
  logic [VERI_BIT-1:0] kaydirilmis;

  assign miktar      = deger2_i[SW-1:0];
  assign kaydirma_op = (kontrol_i == OP_SLL) || (kontrol_i == OP_SRL) || (kontrol_i == OP_SRA);

  // Single-cycle datapath. Shifts here only ever see distance 0 in practice,
  // but computing them generally keeps the mux simple.
  always_comb begin
    tek_sonuc = '0;
    case (kontrol_i)
      OP_ADD:  tek_sonuc = deger1_i + deger2_i;
      OP_SUB:  tek_sonuc = deger1_i + ~deger2_i + VERI_BIT'(1);
      OP_XOR:  tek_sonuc = deger1_i ^ deger2_i;
      OP_OR:   tek_sonuc = deger1_i | deger2_i;
      OP_AND:  tek_sonuc = deger1_i & deger2_i;
      OP_SLL:  tek_sonuc = deger1_i << miktar;
      OP_SRL:  tek_sonuc = deger1_i >> miktar;
      OP_SRA:  tek_sonuc = $signed(deger1_i) >>> miktar;
      OP_SLT:  tek_sonuc[0] = $signed(deger1_i) < $signed(deger2_i);
      OP_SLTU: tek_sonuc[0] = deger1_i < deger2_i;
      default: tek_sonuc = '0;
    endcase
  end

  // Iterative shifter. Arithmetic right shift of the partial value keeps its
  // MSB, which is always the original operand's MSB, so SRA fill is correct.
  assign adim = (kalan_reg > ADIM_K) ? ADIM_K : kalan_reg;

  always_comb begin
    kaydirilmis = veri_reg;
    case (op_reg)
      OP_SLL:  kaydirilmis = veri_reg << adim;
      OP_SRL:  kaydirilmis = veri_reg >> adim;
      OP_SRA:  kaydirilmis = $signed(veri_reg) >>> adim;
      default: kaydirilmis = veri_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    sonuc_next = sonuc_reg;
    veri_next  = veri_reg;
    op_next    = op_reg;
    kalan_next = kalan_reg;

    if (temizle_i) begin
      // Squash: result register keeps its value, only validity is dropped.
      state_next = BOSTA;
    end else begin
      case (state_reg)
        BOSTA: begin
          if (gecerli_i) begin
            if (kaydirma_op && (miktar != '0)) begin
              veri_next  = deger1_i;
              op_next    = kontrol_i;
              kalan_next = {1'b0, miktar};
              state_next = KAYDIR;
            end else begin
              sonuc_next = tek_sonuc;
              state_next = SONUC;
            end
          end
        end
        KAYDIR: begin
          veri_next  = kaydirilmis;
          kalan_next = kalan_reg - adim;
          if (kalan_reg <= ADIM_K) begin
            sonuc_next = kaydirilmis;
            state_next = SONUC;
          end
        end
        SONUC: begin
          if (hazir_i) begin
            state_next = BOSTA;
          end
        end
        default: state_next = BOSTA;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_reg <= BOSTA;
      sonuc_reg <= '0;
      veri_reg  <= '0;
      op_reg    <= '0;
      kalan_reg <= '0;
    end else begin
      state_reg <= state_next;
      sonuc_reg <= sonuc_next;
      veri_reg  <= veri_next;
      op_reg    <= op_next;
      kalan_reg <= kalan_next;
    end
  end

  assign hazir_o   = (state_reg == BOSTA);
  assign gecerli_o = (state_reg == SONUC);
  assign sonuc_o   = sonuc_reg;

endmodule

// File: tb/tb_cok_dongulu_amb.sv
// tb_cok_dongulu_amb -- directed self-checking bench for cok_dongulu_amb
// (VERI_BIT=32, KAYDIRMA_ADIM=8). Expected results and latencies are
// hand-computed constants; latency counts clock edges from the edge that
// samples the accepted op up to the first edge after which gecerli_o is high.
module tb_cok_dongulu_amb;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        temizle_i;
  logic        gecerli_i;
  logic        hazir_o;
  logic [3:0]  kontrol_i;
  logic [31:0] deger1_i;
  logic [31:0] deger2_i;
  logic        gecerli_o;
  logic        hazir_i;
  logic [31:0] sonuc_o;

  int tests_run = 0;
  int tests_failed = 0;

  cok_dongulu_amb #(
    .VERI_BIT      (32),
    .KAYDIRMA_ADIM (8)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .temizle_i (temizle_i),
    .gecerli_i (gecerli_i),
    .hazir_o   (hazir_o),
    .kontrol_i (kontrol_i),
    .deger1_i  (deger1_i),
    .deger2_i  (deger2_i),
    .gecerli_o (gecerli_o),
    .hazir_i   (hazir_i),
    .sonuc_o   (sonuc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one op (hazir_i held at 1), wait for its result with a bounded
  // loop, and check result, latency and the single-cycle valid pulse.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat;
    check_eq({tag, "_ready"}, {31'd0, hazir_o}, 32'd1);
    kontrol_i = op;
    deger1_i  = a;
    deger2_i  = b;
    gecerli_i = 1'b1;
    tick();
    gecerli_i = 1'b0;
    deger1_i  = 32'h0;
    deger2_i  = 32'h0;
    lat = 1;
    while (!gecerli_o && lat < 40) begin
      check_eq({tag, "_busy"}, {31'd0, hazir_o}, 32'd0);
      tick();
      lat++;
    end
    check_eq({tag, "_valid"}, {31'd0, gecerli_o}, 32'd1);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_res"}, sonuc_o, exp_res);
    $display("[TB] %-10s op=%0d a=0x%08h b=0x%08h -> 0x%08h lat=%0d (exp 0x%08h lat=%0d)",
             tag, op, a, b, sonuc_o, lat, exp_res, exp_lat);
    tick();
    check_eq({tag, "_drop"}, {31'd0, gecerli_o}, 32'd0);
    check_eq({tag, "_idle"}, {31'd0, hazir_o}, 32'd1);
  endtask

  initial begin
    rst_i     = 1'b0;
    temizle_i = 1'b0;
    gecerli_i = 1'b0;
    hazir_i   = 1'b1;
    kontrol_i = 4'd0;
    deger1_i  = 32'h0;
    deger2_i  = 32'h0;
    tick();
    tick();
    check_eq("rst_valid", {31'd0, gecerli_o}, 32'd0);
    check_eq("rst_ready", {31'd0, hazir_o}, 32'd1);
    check_eq("rst_res", sonuc_o, 32'h0);
    rst_i = 1'b1;
    tick();
    check_eq("post_rst_ready", {31'd0, hazir_o}, 32'd1);

    // Single-cycle ops
    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    run_op("sub",      4'd1, 32'd5,         32'd7,         32'hFFFF_FFFE, 1);
    run_op("xor",      4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 1);
    run_op("or",       4'd3, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1);
    run_op("and",      4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run_op("slt_neg",  4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
    run_op("sltu_big", 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
    run_op("slt_pos",  4'd8, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    run_op("sltu_sm",  4'd9, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    run_op("op12",     4'd12, 32'd5,        32'd7,         32'h0000_0000, 1);

    // Shifts: latency 1 + ceil(s/8) for s>0, 1 for s==0
    run_op("sll_0",    4'd5, 32'h0000_0001, 32'd0,         32'h0000_0001, 1);
    run_op("srl_8",    4'd6, 32'hF000_0000, 32'd8,         32'h00F0_0000, 2);
    run_op("sra_31",   4'd7, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 5);
    run_op("sll_17",   4'd5, 32'h0000_0003, 32'd17,        32'h0006_0000, 4);
    run_op("sra_pos4", 4'd7, 32'h7000_0000, 32'd4,         32'h0700_0000, 2);
    run_op("sra_8",    4'd7, 32'h8000_0000, 32'd8,         32'hFF80_0000, 2);
    run_op("srl_hib",  4'd6, 32'h8000_0000, 32'h0000_0124, 32'h0800_0000, 2);

    // Back-pressure: result held for 3 cycles, new ops ignored
    hazir_i   = 1'b0;
    kontrol_i = 4'd0;
    deger1_i  = 32'd2;
    deger2_i  = 32'd3;
    gecerli_i = 1'b1;
    tick();
    kontrol_i = 4'd0;
    deger1_i  = 32'd7;
    deger2_i  = 32'd7;
    for (int i = 0; i < 4; i++) begin
      check_eq("hold_valid", {31'd0, gecerli_o}, 32'd1);
      check_eq("hold_res", sonuc_o, 32'd5);
      check_eq("hold_ready", {31'd0, hazir_o}, 32'd0);
      if (i < 3) tick();
    end
    $display("[TB] hold       result 0x%08h held 3 extra cycles with hazir_i=0", sonuc_o);
    gecerli_i = 1'b0;
    hazir_i   = 1'b1;
    tick();
    check_eq("hold_release", {31'd0, gecerli_o}, 32'd0);
    check_eq("hold_idle", {31'd0, hazir_o}, 32'd1);

    // Flush mid-shift; an op presented with the flush must not be taken
    run_op("xor_pre", 4'd2, 32'h0F0F_0000, 32'h0000_0F0F, 32'h0F0F_0F0F, 1);
    kontrol_i = 4'd5;
    deger1_i  = 32'h0000_0001;
    deger2_i  = 32'd31;
    gecerli_i = 1'b1;
    tick();
    gecerli_i = 1'b0;
    check_eq("flush_busy", {31'd0, hazir_o}, 32'd0);
    tick();
    temizle_i = 1'b1;
    gecerli_i = 1'b1;
    kontrol_i = 4'd0;
    deger1_i  = 32'd1;
    deger2_i  = 32'd1;
    tick();
    temizle_i = 1'b0;
    gecerli_i = 1'b0;
    check_eq("flush_valid", {31'd0, gecerli_o}, 32'd0);
    check_eq("flush_ready", {31'd0, hazir_o}, 32'd1);
    check_eq("flush_res_kept", sonuc_o, 32'h0F0F_0F0F);
    tick();
    check_eq("flush_no_accept", {31'd0, gecerli_o}, 32'd0);
    $display("[TB] flush      mid-KAYDIR squash, sonuc_o=0x%08h gecerli_o=%0b", sonuc_o, gecerli_o);
    run_op("add_aft_fl", 4'd0, 32'd2, 32'd3, 32'd5, 1);

    // Reset mid-shift
    kontrol_i = 4'd7;
    deger1_i  = 32'h8000_0000;
    deger2_i  = 32'd31;
    gecerli_i = 1'b1;
    tick();
    gecerli_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    check_eq("mrst_valid", {31'd0, gecerli_o}, 32'd0);
    check_eq("mrst_ready", {31'd0, hazir_o}, 32'd1);
    check_eq("mrst_res", sonuc_o, 32'h0);
    tick();
    check_eq("mrst_stay", {31'd0, gecerli_o}, 32'd0);
    $display("[TB] reset      mid-KAYDIR, sonuc_o=0x%08h gecerli_o=%0b", sonuc_o, gecerli_o);
    run_op("add_aft_rs", 4'd0, 32'd2, 32'd3, 32'd5, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
